// File: rtl/pipe_pkg.sv
// Shared definitions for the immediate-extension path.
// Mode encoding is shared with the instruction decoder that generates it,
// so values here must stay in sync with the decode tables.
package pipe_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    EXT_ZERO  = 3'd0,  // {0, imm}
    EXT_SIGN  = 3'd1,  // sign-extend imm
    EXT_BROFF = 3'd2,  // sign-extend {imm, 2'b00}
    EXT_HIGH  = 3'd3,  // {imm, 0...} (LUI)
    EXT_SHAMT = 3'd4   // zero-extend low SHAMT_W bits
  } ext_mode_e;

endpackage

// File: rtl/pipe_imm_ext_if.sv
// Bus bundle for pipe_imm_ext.
//   master : upstream/downstream side (drives inputs, out_ready, flush)
//   slave  : the extension pipeline itself
interface pipe_imm_ext_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic [IN_W-1:0]             imm_in;
  logic [pipe_pkg::MODE_W-1:0] mode;
  logic                        out_valid;
  logic                        out_ready;
  logic [OUT_W-1:0]            imm_out;
  logic                        mode_err;

  modport master (
    output flush, in_valid, imm_in, mode, out_ready,
    input  in_ready, out_valid, imm_out, mode_err
  );

  modport slave (
    input  flush, in_valid, imm_in, mode, out_ready,
    output in_ready, out_valid, imm_out, mode_err
  );
endinterface

// File: rtl/pipe_imm_ext_core.sv
// Combinational mode mux: turns a raw immediate field into an OUT_W result.
// Ports:
//   i_imm  [IN_W]   raw immediate field
//   i_mode [MODE_W] extension mode (pipe_pkg::ext_mode_e)
//   o_res  [OUT_W]  extended result (0 for reserved modes)
//   o_err           reserved mode seen
module imm_ext_core
  import pipe_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [IN_W-1:0]   i_imm,
  input  logic [MODE_W-1:0] i_mode,
  output logic [OUT_W-1:0]  o_res,
  output logic              o_err
);

  if (OUT_W < IN_W + 2) begin : g_bad_out_w
    $error("imm_ext_core: OUT_W must be >= IN_W+2");
  end
  if (SHAMT_W > IN_W) begin : g_bad_shamt_w
    $error("imm_ext_core: SHAMT_W must be <= IN_W");
  end

  // Signed views: a size cast of a signed operand sign-extends, which
  // stays legal even when OUT_W == IN_W+2 (no zero-width replication).
  logic signed [IN_W-1:0] w_simm;
  logic signed [IN_W+1:0] w_sbr;

  assign w_simm = i_imm;
  assign w_sbr  = {i_imm, 2'b00};

  always_comb begin
    o_res = '0;
    o_err = 1'b0;
    case (i_mode)
      EXT_ZERO:  o_res = OUT_W'(i_imm);
      EXT_SIGN:  o_res = OUT_W'(w_simm);
      EXT_BROFF: o_res = OUT_W'(w_sbr);
      EXT_HIGH:  o_res = {i_imm, {(OUT_W-IN_W){1'b0}}};
      EXT_SHAMT: o_res = OUT_W'(i_imm[SHAMT_W-1:0]);
      default:   o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_imm_ext.sv
// Pipelined immediate-extension unit (ID -> EX).
// Extension happens combinationally on the input side and is captured into
// stage 0; further stages only carry valid/data/err. Empty stages collapse,
// flush kills everything in flight (including a same-cycle input).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pipe_imm_ext_if.slave: flush, in_valid/in_ready, imm_in, mode,
//          out_valid/out_ready, imm_out, mode_err
module pipe_imm_ext
  import pipe_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 32,
  parameter int SHAMT_W = 5,
  parameter int STAGES  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_imm_ext_if.slave bus
);

  if (OUT_W < IN_W + 2 || SHAMT_W > IN_W || STAGES < 1 || STAGES > 4)
  begin : g_bad_param
    $error("pipe_imm_ext: illegal parameter combination");
  end

  logic [OUT_W-1:0] w_ext;
  logic             w_ext_err;

  imm_ext_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .i_imm  (bus.imm_in),
    .i_mode (bus.mode),
    .o_res  (w_ext),
    .o_err  (w_ext_err)
  );

  logic [STAGES-1:0]            w_vld;
  logic [STAGES-1:0]            w_err;
  logic [STAGES-1:0][OUT_W-1:0] w_data;
  logic [STAGES-1:0]            w_go;   // stage k may load this cycle

  // Readiness ripples back from the output: a stage can load if it is empty
  // or its occupant moves on. This makes in_ready combinational on out_ready.
  always_comb begin
    w_go = '0;
    w_go[STAGES-1] = !w_vld[STAGES-1] || bus.out_ready;
    for (int k = STAGES - 2; k >= 0; k--)
      w_go[k] = !w_vld[k] || w_go[k+1];
  end

  assign bus.in_ready = w_go[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic             r_vld;
    logic             r_err;
    logic [OUT_W-1:0] r_data;
    logic             w_pv;
    logic             w_perr;
    logic [OUT_W-1:0] w_pdata;

    if (k == 0) begin : g_head
      assign w_pv    = bus.in_valid;
      assign w_pdata = w_ext;
      assign w_perr  = w_ext_err;
    end else begin : g_body
      assign w_pv    = w_vld[k-1];
      assign w_pdata = w_data[k-1];
      assign w_perr  = w_err[k-1];
    end

    // Loading from an empty predecessor leaves a bubble; data is only
    // overwritten by a real beat so a stalled output never changes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld  <= 1'b0;
        r_err  <= 1'b0;
        r_data <= '0;
      end else if (bus.flush) begin
        r_vld <= 1'b0;
      end else if (w_go[k]) begin
        r_vld <= w_pv;
        if (w_pv) begin
          r_data <= w_pdata;
          r_err  <= w_perr;
        end
      end
    end

    assign w_vld[k]  = r_vld;
    assign w_err[k]  = r_err;
    assign w_data[k] = r_data;
  end

  assign bus.out_valid = w_vld[STAGES-1];
  assign bus.imm_out   = w_data[STAGES-1];
  assign bus.mode_err  = w_err[STAGES-1];

endmodule

// File: tb/tb_pipe_imm_ext.sv
// Bench for pipe_imm_ext: three instances (STAGES = 1, 2, 3) share stimulus;
// only the one picked by sel receives in_valid. A negedge monitor keeps a
// scoreboard queue of expected {err, data} for the selected instance.
module tb_pipe_imm_ext;
  import pipe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel;
  logic        tv, tflush, tordy;
  logic [15:0] timm;
  logic [2:0]  tmode;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  logic [32:0] q[$];

  pipe_imm_ext_if #(.IN_W(16), .OUT_W(32)) b1();
  pipe_imm_ext_if #(.IN_W(16), .OUT_W(32)) b2();
  pipe_imm_ext_if #(.IN_W(16), .OUT_W(32)) b3();

  assign b1.in_valid = tv && sel == 2'd0;
  assign b2.in_valid = tv && sel == 2'd1;
  assign b3.in_valid = tv && sel == 2'd2;
  assign b1.imm_in = timm;  assign b2.imm_in = timm;  assign b3.imm_in = timm;
  assign b1.mode = tmode;   assign b2.mode = tmode;   assign b3.mode = tmode;
  assign b1.flush = tflush; assign b2.flush = tflush; assign b3.flush = tflush;
  assign b1.out_ready = tordy; assign b2.out_ready = tordy; assign b3.out_ready = tordy;

  pipe_imm_ext #(.IN_W(16), .OUT_W(32), .SHAMT_W(5), .STAGES(1))
    u_s1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  pipe_imm_ext #(.IN_W(16), .OUT_W(32), .SHAMT_W(5), .STAGES(2))
    u_s2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  pipe_imm_ext #(.IN_W(16), .OUT_W(32), .SHAMT_W(5), .STAGES(3))
    u_s3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  // Outputs of the selected instance
  logic        s_ov, s_ir, s_err;
  logic [31:0] s_imm;
  always_comb begin
    s_ov = b1.out_valid; s_ir = b1.in_ready; s_err = b1.mode_err; s_imm = b1.imm_out;
    case (sel)
      2'd1: begin s_ov = b2.out_valid; s_ir = b2.in_ready; s_err = b2.mode_err; s_imm = b2.imm_out; end
      2'd2: begin s_ov = b3.out_valid; s_ir = b3.in_ready; s_err = b3.mode_err; s_imm = b3.imm_out; end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic logic [32:0] model(input logic [2:0] m, input logic [15:0] v);
    case (m)
      3'd0:    return {1'b0, 16'h0000, v};
      3'd1:    return {1'b0, {16{v[15]}}, v};
      3'd2:    return {1'b0, {14{v[15]}}, v, 2'b00};
      3'd3:    return {1'b0, v, 16'h0000};
      3'd4:    return {1'b0, 27'd0, v[4:0]};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: pop on output transfer, then flush clears, else push on accept
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (s_ov && tordy) begin
        n_out++;
        if (q.size() == 0) chk("sb_spurious", 64'd1, 64'd0);
        else chk("sb_beat", {31'd0, s_err, s_imm}, {31'd0, q.pop_front()});
      end
      if (tflush) q.delete();
      else if (tv && s_ir) q.push_back(model(tmode, timm));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic [15:0] d);
    tv = v; tmode = m; timm = d;
  endtask

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] imm;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [15:0] beats[3];
    logic [7:0]  ovp;
    logic [4:0]  irp;
    int idx, guard, base;
    logic seen;

    tbl[0]  = '{3'd0, 16'h8004, 32'h00008004, 1'b0};
    tbl[1]  = '{3'd1, 16'h8004, 32'hFFFF8004, 1'b0};
    tbl[2]  = '{3'd2, 16'h8004, 32'hFFFE0010, 1'b0};
    tbl[3]  = '{3'd3, 16'h8004, 32'h80040000, 1'b0};
    tbl[4]  = '{3'd4, 16'h8004, 32'h00000004, 1'b0};
    tbl[5]  = '{3'd6, 16'h1234, 32'h00000000, 1'b1};
    tbl[6]  = '{3'd1, 16'h7FFF, 32'h00007FFF, 1'b0};
    tbl[7]  = '{3'd2, 16'h7FFF, 32'h0001FFFC, 1'b0};
    tbl[8]  = '{3'd2, 16'hFFFF, 32'hFFFFFFFC, 1'b0};
    tbl[9]  = '{3'd4, 16'hFFFF, 32'h0000001F, 1'b0};
    tbl[10] = '{3'd3, 16'h0001, 32'h00010000, 1'b0};
    tbl[11] = '{3'd5, 16'hABCD, 32'h00000000, 1'b1};
    tbl[12] = '{3'd7, 16'hFFFF, 32'h00000000, 1'b1};

    rst_n = 1'b0; sel = 2'd0; tflush = 1'b0; tordy = 1'b1;
    drive(1'b0, 3'd0, 16'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset state of every instance: {out_valid, imm_out, mode_err, in_ready}
    chk("rst_s1", {b1.out_valid, b1.imm_out, b1.mode_err, b1.in_ready}, {1'b0, 32'h0, 1'b0, 1'b1});
    chk("rst_s2", {b2.out_valid, b2.imm_out, b2.mode_err, b2.in_ready}, {1'b0, 32'h0, 1'b0, 1'b1});
    chk("rst_s3", {b3.out_valid, b3.imm_out, b3.mode_err, b3.in_ready}, {1'b0, 32'h0, 1'b0, 1'b1});

    // Mode table, STAGES=1: each beat visible right after its accepting edge
    sel = 2'd0;
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, tbl[i].mode, tbl[i].imm);
      step();
      chk($sformatf("tbl%0d", i), {s_ov, s_err, s_imm}, {1'b1, tbl[i].err, tbl[i].exp});
    end
    drive(1'b0, 3'd0, 16'h0);
    step();
    chk("tbl_idle", {63'd0, s_ov}, 64'd0);

    // STAGES=3: 4 back-to-back beats, out_valid pattern per cycle after accepts
    sel = 2'd2;
    ovp = '0;
    for (int j = 0; j < 8; j++) begin
      if (j < 4) drive(1'b1, 3'd1, 16'(j + 1));
      else drive(1'b0, 3'd0, 16'h0);
      step();
      ovp[j] = s_ov;
    end
    chk("s3_latency", {56'd0, ovp}, {56'd0, 8'b0011_1100});
    chk("s3_drained", q.size(), 64'd0);

    // Stall, STAGES=2: out_ready low for 5 cycles while offering 3 beats
    sel = 2'd1;
    tordy = 1'b0;
    beats[0] = 16'h8001; beats[1] = 16'h0002; beats[2] = 16'hC003;
    idx = 0; irp = '0; base = n_out;
    for (int c = 0; c < 5; c++) begin
      if (idx < 3) drive(1'b1, 3'(idx + 1), beats[idx]);
      else drive(1'b0, 3'd0, 16'h0);
      #1;
      irp[c] = s_ir;
      if (s_ir) idx++;
      step();
    end
    chk("stall_in_ready", {59'd0, irp}, {59'd0, 5'b00011});
    chk("stall_hold", {s_ov, s_imm}, {1'b1, 32'hFFFF8001});
    tordy = 1'b1;
    guard = 0;
    while (idx < 3 && guard < 10) begin
      drive(1'b1, 3'(idx + 1), beats[idx]);
      #1;
      if (s_ir) idx++;
      step();
      guard++;
    end
    drive(1'b0, 3'd0, 16'h0);
    chk("stall_accept_timeout", idx, 64'd3);
    guard = 0;
    while ((q.size() != 0 || s_ov) && guard < 20) begin step(); guard++; end
    chk("stall_drain_timeout", {63'd0, guard >= 20}, 64'd0);
    chk("stall_count", n_out - base, 64'd3);

    // Flush, STAGES=2: two beats in flight plus a same-cycle input
    tordy = 1'b0;
    drive(1'b1, 3'd0, 16'h1111); step();
    drive(1'b1, 3'd0, 16'h2222); step();
    drive(1'b1, 3'd0, 16'h3333); tflush = 1'b1;
    step();
    tflush = 1'b0;
    drive(1'b0, 3'd0, 16'h0);
    chk("flush_ov", {63'd0, s_ov}, 64'd0);
    tordy = 1'b1;
    base = n_out; seen = 1'b0;
    for (int c = 0; c < 5; c++) begin step(); seen |= s_ov; end
    chk("flush_none_emerge", {63'd0, seen}, 64'd0);
    chk("flush_count", n_out - base, 64'd0);
    // Flush on an empty pipe while in_ready=1: the offered beat is dropped
    drive(1'b1, 3'd1, 16'h4444); tflush = 1'b1;
    #1;
    chk("flush_ir", {63'd0, s_ir}, 64'd1);
    step();
    tflush = 1'b0;
    drive(1'b0, 3'd0, 16'h0);
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin seen |= s_ov; step(); end
    chk("flush_same_cycle", {63'd0, seen}, 64'd0);
    // Normal beat afterwards
    base = n_out;
    drive(1'b1, 3'd2, 16'h0005); step();
    drive(1'b0, 3'd0, 16'h0);
    guard = 0;
    while (n_out == base && guard < 10) begin step(); guard++; end
    chk("post_flush_beat", n_out - base, 64'd1);

    // Async reset mid-stream with STAGES=2 full
    tordy = 1'b0;
    drive(1'b1, 3'd3, 16'hBEEF); step();
    drive(1'b1, 3'd1, 16'hCAFE); step();
    drive(1'b0, 3'd0, 16'h0);
    chk("rst_pre_full", {62'd0, s_ov, s_ir}, {62'd0, 2'b10});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {s_ov, s_err, s_imm}, {1'b0, 1'b0, 32'h0});
    step(); step();
    #2;
    rst_n = 1'b1;
    tordy = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin step(); seen |= s_ov; end
    chk("rst_no_spurious", {63'd0, seen}, 64'd0);
    chk("rst_q_empty", q.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
